// File: rtl/uart_mem_burst_bridge_if.sv
// Byte-stream and dual-port RAM signals of the UART memory burst bridge.
// master: the bridge itself; slave: UART engines plus RAM side.
interface uart_mem_burst_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_BYTES = 4
);
  logic                      rx_valid;
  logic [7:0]                rx_data;
  logic                      tx_ready;
  logic                      tx_valid;
  logic [7:0]                tx_data;
  logic [ADDR_WIDTH-1:0]     addra;
  logic [DATA_BYTES-1:0]     wea;
  logic [8*DATA_BYTES-1:0]   dia;
  logic [ADDR_WIDTH-1:0]     addrb;
  logic [8*DATA_BYTES-1:0]   dob;

  modport master (
    input  rx_valid, rx_data, tx_ready, dob,
    output tx_valid, tx_data, addra, wea, dia, addrb
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, dob,
    input  tx_valid, tx_data, addra, wea, dia, addrb
  );
endinterface

// File: rtl/uart_mem_burst_bridge.sv
// UART byte-stream command bridge to a true-dual-port RAM: burst writes on port A with
// byte masks and ACK/NAK, burst reads on port B streamed back LSB first.
module uart_mem_burst_bridge #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  OP_WRITE       = 8'h0F,
  parameter logic [7:0]  OP_READ        = 8'hFF,
  parameter logic [7:0]  ACK_BYTE       = 8'hAC,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_mem_burst_bridge_if.master  bus,
  output logic                     busy
);
  localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned AB_W       = 8 * ADDR_BYTES;
  localparam int unsigned DW         = 8 * DATA_BYTES;
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  HDR_LAST   = 8'(ADDR_BYTES);
  localparam logic [7:0]  DATA_LAST  = 8'(DATA_BYTES - 1);
  localparam logic [7:0]  LAT_LAST   = 8'(READ_LATENCY);

  typedef enum logic [3:0] {
    StIdle, StHdr, StBe, StWdata, StWcommit, StRissue, StRwait, StRsend, StResp
  } state_e;

  state_e                  state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              idx_q, idx_d;
  logic [7:0]              lat_q, lat_d;
  logic [31:0]             to_q, to_d;
  logic [AB_W-1:0]         addr_sh_q, addr_sh_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_BYTES-1:0]   mask_q, mask_d;
  logic [DW-1:0]           word_q, word_d;
  logic [DW-1:0]           txsh_q, txsh_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
  logic [DATA_BYTES-1:0]   wea_q, wea_d;
  logic [DW-1:0]           dia_q, dia_d;
  logic [ADDR_WIDTH-1:0]   addrb_q, addrb_d;

  // Fields arrive LSB first, so each new byte enters at the top of a right shift.
  logic [AB_W-1:0] addr_next;
  logic [DW-1:0]   word_next;
  logic [DW-1:0]   tx_next;
  assign addr_next = AB_W'({bus.rx_data, addr_sh_q} >> 8);
  assign word_next = DW'({bus.rx_data, word_q} >> 8);
  assign tx_next   = txsh_q >> 8;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    to_d       = '0;
    addr_sh_d  = addr_sh_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    word_d     = word_q;
    txsh_d     = txsh_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    addra_d    = addra_q;
    wea_d      = '0;
    dia_d      = dia_q;
    addrb_d    = addrb_q;

    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          idx_d = '0;
          if (bus.rx_data == OP_WRITE) begin
            is_write_d = 1'b1;
            state_d    = StHdr;
          end else if (bus.rx_data == OP_READ) begin
            is_write_d = 1'b0;
            state_d    = StHdr;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = NAK_BYTE;
            state_d    = StResp;
          end
        end
      end
      StHdr, StBe, StWdata: begin
        if (bus.rx_valid) begin
          if (state_q == StHdr) begin
            idx_d = idx_q + 8'd1;
            if (idx_q == 8'd0) cnt_d = bus.rx_data;
            else addr_sh_d = addr_next;
            if (idx_q == HDR_LAST) begin
              idx_d   = '0;
              addr_d  = addr_next[ADDR_WIDTH-1:0];
              state_d = is_write_q ? StBe : StRissue;
            end
          end else if (state_q == StBe) begin
            mask_d  = bus.rx_data[DATA_BYTES-1:0];
            idx_d   = '0;
            state_d = StWdata;
          end else begin
            word_d = word_next;
            idx_d  = idx_q + 8'd1;
            if (idx_q == DATA_LAST) begin
              idx_d   = '0;
              addra_d = addr_q;
              dia_d   = word_next;
              wea_d   = mask_q;
              state_d = StWcommit;
            end
          end
        end else if (to_q == TO_LAST) begin
          tx_valid_d = 1'b1;
          tx_data_d  = NAK_BYTE;
          state_d    = StResp;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      StWcommit: begin
        if (cnt_q == 8'd0) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          state_d    = StResp;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = StWdata;
        end
      end
      StRissue: begin
        addrb_d = addr_q;
        lat_d   = '0;
        state_d = StRwait;
      end
      StRwait: begin
        lat_d = lat_q + 8'd1;
        if (lat_q == LAT_LAST) begin
          txsh_d     = bus.dob;
          tx_data_d  = bus.dob[7:0];
          tx_valid_d = 1'b1;
          idx_d      = '0;
          state_d    = StRsend;
        end
      end
      StRsend: begin
        if (bus.tx_ready) begin
          if (idx_q == DATA_LAST) begin
            tx_valid_d = 1'b0;
            if (cnt_q == 8'd0) begin
              state_d = StIdle;
            end else begin
              cnt_d   = cnt_q - 8'd1;
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = StRissue;
            end
          end else begin
            idx_d     = idx_q + 8'd1;
            txsh_d    = tx_next;
            tx_data_d = tx_next[7:0];
          end
        end
      end
      StResp: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      to_q       <= '0;
      addr_sh_q  <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      word_q     <= '0;
      txsh_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      addra_q    <= '0;
      wea_q      <= '0;
      dia_q      <= '0;
      addrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      to_q       <= to_d;
      addr_sh_q  <= addr_sh_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      word_q     <= word_d;
      txsh_q     <= txsh_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      addra_q    <= addra_d;
      wea_q      <= wea_d;
      dia_q      <= dia_d;
      addrb_q    <= addrb_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.addra    = addra_q;
  assign bus.wea      = wea_q;
  assign bus.dia      = dia_q;
  assign bus.addrb    = addrb_q;
  assign busy         = (state_q != StIdle);
endmodule

// File: tb/tb_uart_mem_burst_bridge.sv
// Directed bench for uart_mem_burst_bridge: writes, masked wrapping burst, read burst with
// back-pressure, bad opcode, inter-byte timeout and reset in mid-burst.
module tb_uart_mem_burst_bridge;
  localparam int unsigned AW = 16;
  localparam int unsigned DB = 4;
  localparam int unsigned RL = 2;
  localparam int unsigned TO = 100;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  we;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  txq[$];
  wr_t         wrq[$];
  logic [31:0] mem [0:65535];
  logic [31:0] rd_pipe [RL];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  uart_mem_burst_bridge_if #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) bus ();

  uart_mem_burst_bridge #(
    .ADDR_WIDTH(AW), .DATA_BYTES(DB), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy)
  );

  // RAM model: byte-masked write on A, READ_LATENCY-stage registered read on B.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    for (int b = 0; b < DB; b++) if (bus.wea[b]) mem[bus.addra][8*b +: 8] <= bus.dia[8*b +: 8];
    rd_pipe[0] <= mem[bus.addrb];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.dob = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    if (bus.wea != '0) wrq.push_back('{a: bus.addra, we: bus.wea, d: bus.dia});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
    check(tag, 64'(txq.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
    check({tag, "_tx_data"}, 64'(bus.tx_data), 64'd0);
    check({tag, "_addra"}, 64'(bus.addra), 64'd0);
    check({tag, "_wea"}, 64'(bus.wea), 64'd0);
    check({tag, "_dia"}, 64'(bus.dia), 64'd0);
    check({tag, "_addrb"}, 64'(bus.addrb), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  logic [7:0] exp_rd [8];
  logic [7:0] held;
  logic       stable;
  int         nwr;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b1;
    exp_rd = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hBE, 8'hBA, 8'hFE, 8'hCA};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single full-mask write.
    txq.delete(); wrq.delete();
    send(8'h0F); send(8'h00); send(8'h34); send(8'h12); send(8'h0F);
    send_word(32'h12345678);
    wait_tx("wr1_tx_count", 1, 50);
    check("wr1_ack", 64'(txq[0]), 64'hAC);
    check("wr1_nwrites", 64'(wrq.size()), 64'd1);
    check("wr1_addra", 64'(wrq[0].a), 64'h1234);
    check("wr1_wea", 64'(wrq[0].we), 64'hF);
    check("wr1_dia", 64'(wrq[0].d), 64'h12345678);
    wait_idle("wr1_idle");

    // Masked burst of three words wrapping through 0xFFFF.
    txq.delete(); wrq.delete();
    send(8'h0F); send(8'h02); send(8'hFE); send(8'hFF); send(8'h05);
    send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
    wait_tx("burst_tx_count", 1, 50);
    check("burst_ack", 64'(txq[0]), 64'hAC);
    check("burst_nwrites", 64'(wrq.size()), 64'd3);
    check("burst_a0", 64'(wrq[0].a), 64'hFFFE);
    check("burst_a1", 64'(wrq[1].a), 64'hFFFF);
    check("burst_a2", 64'(wrq[2].a), 64'h0000);
    check("burst_we0", 64'(wrq[0].we), 64'h5);
    check("burst_we2", 64'(wrq[2].we), 64'h5);
    check("burst_d1", 64'(wrq[1].d), 64'h22222222);
    check("burst_d2", 64'(wrq[2].d), 64'h33333333);
    wait_idle("burst_idle");

    // Two-word read burst with 50 cycles of TX back-pressure after the third byte.
    preload(16'h0010, 32'h12345678);
    preload(16'h0011, 32'hCAFEBABE);
    txq.delete(); wrq.delete();
    send(8'hFF); send(8'h01); send(8'h10); send(8'h00);
    for (int i = 0; i < 100 && txq.size() < 3; i++) @(negedge clk);
    check("bp_pre_count", 64'(txq.size()), 64'd3);
    bus.tx_ready = 1'b0;
    held   = bus.tx_data;
    stable = bus.tx_valid;
    repeat (50) begin
      @(negedge clk);
      if (!bus.tx_valid || bus.tx_data !== held) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_held_byte", 64'(held), 64'h12);
    check("bp_no_accept", 64'(txq.size()), 64'd3);
    bus.tx_ready = 1'b1;
    wait_tx("rd_tx_count", 8, 100);
    for (int i = 0; i < 8; i++) check($sformatf("rd_byte%0d", i), 64'(txq[i]), 64'(exp_rd[i]));
    wait_idle("rd_idle");
    repeat (5) @(negedge clk);
    check("rd_no_extra", 64'(txq.size()), 64'd8);
    check("rd_no_writes", 64'(wrq.size()), 64'd0);

    // Unknown opcode.
    txq.delete();
    send(8'h42);
    wait_tx("nak_op_count", 1, 20);
    check("nak_op", 64'(txq[0]), 64'hEE);
    wait_idle("nak_op_idle");

    // Write frame stalled in the header.
    txq.delete(); wrq.delete();
    send(8'h0F); send(8'h01); send(8'h00);
    repeat (90) @(negedge clk);
    check("to_early_count", 64'(txq.size()), 64'd0);
    check("to_busy", 64'(busy), 64'd1);
    wait_tx("to_count", 1, 40);
    check("to_nak", 64'(txq[0]), 64'hEE);
    check("to_no_writes", 64'(wrq.size()), 64'd0);
    wait_idle("to_idle");

    // Reset after two of four burst words have been committed.
    txq.delete(); wrq.delete();
    send(8'h0F); send(8'h03); send(8'h00); send(8'h02); send(8'h0F);
    send_word(32'hAABBCCDD); send_word(32'h11223344);
    repeat (2) @(negedge clk);
    check("rst_mid_nwrites", 64'(wrq.size()), 64'd2);
    check("rst_mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    rst_n = 1'b1;
    txq.delete();
    send(8'hFF); send(8'h00); send(8'h00); send(8'h02);
    wait_tx("post_rst_count", 4, 100);
    check("post_rst_b0", 64'(txq[0]), 64'hDD);
    check("post_rst_b1", 64'(txq[1]), 64'hCC);
    check("post_rst_b2", 64'(txq[2]), 64'hBB);
    check("post_rst_b3", 64'(txq[3]), 64'hAA);
    wait_idle("post_rst_idle");
    check("post_rst_nwrites", 64'(wrq.size()), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
